uart_parameters_unit: RTL and testbench
=======================================

// Module: uart_parameters_unit
// PURPOSE
//  Single source of UART configuration constants plus the shared baud-timing counter.
//  Instanced by UART blocks as `params`; its localparams are referenced hierarchically
//  (params.CLOCK_FREQ, params.BAUD_RATE, params.WORD_SIZE, params.BAUD_LIMIT, ...).
//  Also exports the constants on ports.
//  Drives the baud/quarter-baud/late-sample strobes used by the receiver and transmitter FSMs.
// PARAMETERS
//  CLOCK_FREQ   100_000_000  system clock frequency, Hz
//  BAUD_RATE    9600         serial bit rate, bits/s
//  WORD_SIZE    8            data bits per frame (5..16)
//  STOP_BITS    1            stop bits per frame (1 or 2)
//  Derived localparams, integer arithmetic:
//   BAUD_LIMIT   = CLOCK_FREQ/BAUD_RATE
//   QTR_BAUD     = BAUD_LIMIT/4
//   THR_QTR_BAUD = (BAUD_LIMIT*4)/5
//   CNT_W        = 16
//   BIT_CNT_W    = $clog2(WORD_SIZE)
// PORTS
//  clk             in   1      system clock, all logic on rising edge
//  rst             in   1      synchronous, active-high reset
//  run             in   1      1: counter advances; 0: counter held at 0 (idle line)
//  restart         in   1      load counter with 1 (start-bit edge detected)
//  resync          in   1      load counter with 0 (re-centre on sample point)
//  baud_cnt        out  16     current baud counter value
//  baud_tick       out  1      baud_cnt == 0
//  qtr_tick        out  1      baud_cnt == QTR_BAUD
//  thr_qtr_tick    out  1      baud_cnt == THR_QTR_BAUD
//  cfg_clock_freq  out  32     CLOCK_FREQ constant
//  cfg_baud_rate   out  32     BAUD_RATE constant
//  cfg_word_size   out  8      WORD_SIZE constant
//  cfg_baud_limit  out  16     BAUD_LIMIT constant
// BEHAVIOUR
//  - Reset:
//    - baud_cnt <= 0, so baud_tick = 1 and qtr_tick = thr_qtr_tick = 0 in the cycle after reset.
//    - cfg_* outputs are constants and are unaffected by reset.
//  - Counter update priority per clk edge: rst > resync > restart > run.
//    - resync: baud_cnt <= 0.
//    - restart: baud_cnt <= 1.
//    - run=1: if baud_cnt == BAUD_LIMIT then 0, else +1.
//    - run=0: baud_cnt <= 0.
//  - Period: count sequence 0..BAUD_LIMIT inclusive, i.e. BAUD_LIMIT+1 clocks per bit.
//  - Strobes are combinational decodes of baud_cnt, so there is zero latency from the counter.
//    qtr_tick and thr_qtr_tick each fire once per period.
//  - restart and resync may be asserted while run=0; they take effect regardless of run.
//  - Elaboration checks (fatal): BAUD_RATE > 0; BAUD_LIMIT in 8..65535; WORD_SIZE in 5..16;
//    STOP_BITS in {1,2}; QTR_BAUD < THR_QTR_BAUD.
//  - No other state. X on run, restart or resync must not corrupt the counter after rst.
// STRUCTURE
//  - Shared package uart_pkg: default CLOCK_FREQ, BAUD_RATE and WORD_SIZE, the derivation
//    functions for the limits, and the RX/TX FSM state encodings (IDLE, START, WAIT, LISTEN,
//    STOP, SECONDWAIT).
//  - One sub-module, uart_baud_counter, holds the counter and strobe decode.
//    The top level holds the localparams, checks and cfg_* wiring.
// TESTING (bench overrides CLOCK_FREQ=1000, BAUD_RATE=100 -> BAUD_LIMIT=10, QTR=2, THR_QTR=8)
//  - Reset: rst=1 for 2 clks -> baud_cnt=0, baud_tick=1, cfg_baud_limit=10, cfg_word_size=8.
//  - run=1 for 22 clks -> baud_cnt 0..10 then wraps to 0; baud_tick every 11 clks;
//    qtr_tick at cnt 2, thr_qtr_tick at cnt 8.
//  - run=0 mid-count (cnt=5) -> next cnt=0; held at 0 while run stays 0.
//  - restart at cnt=7 -> next cnt=1; resync with restart at cnt=3 -> next cnt=0 (resync wins).
//  - rst asserted at cnt=6 with run=1 -> next cnt=0; counting resumes at 1 after rst drops.
//  - Defaults elaborate -> cfg_baud_limit=10416; BAUD_RATE=1 with CLOCK_FREQ=100M -> fatal.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default line configuration, timing derivations and the
// RX/TX FSM state encodings used by the receiver and transmitter blocks.
package uart_pkg;

  localparam int DEF_CLOCK_FREQ = 100_000_000;
  localparam int DEF_BAUD_RATE  = 9600;
  localparam int DEF_WORD_SIZE  = 8;
  localparam int DEF_STOP_BITS  = 1;
  localparam int UART_CNT_W     = 16;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [ST_W-1:0] ST_START      = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT       = 3'd2;
  localparam logic [ST_W-1:0] ST_LISTEN     = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP       = 3'd4;
  localparam logic [ST_W-1:0] ST_SECONDWAIT = 3'd5;

  typedef struct packed {
    logic baud;
    logic qtr;
    logic thr_qtr;
  } baud_strobe_t;

  // A zero rate yields a zero limit so the range check fires instead of a divide fault.
  function automatic int calc_baud_limit(input int clock_freq, input int baud_rate);
    return (baud_rate > 0) ? clock_freq / baud_rate : 0;
  endfunction

  function automatic int calc_qtr_baud(input int baud_limit);
    return baud_limit / 4;
  endfunction

  function automatic int calc_thr_qtr_baud(input int baud_limit);
    return (baud_limit * 4) / 5;
  endfunction

endpackage

// File: rtl/uart_parameters_unit_if.sv
// Baud-timing bus between the parameters unit and the UART FSMs.
interface uart_parameters_unit_if;
  import uart_pkg::*;

  // No handshake: run/restart/resync are level controls sampled every clk edge;
  // baud_cnt and the strobes are valid every cycle with no ready/backpressure.
  logic                  run;
  logic                  restart;
  logic                  resync;
  logic [UART_CNT_W-1:0] baud_cnt;
  logic                  baud_tick;
  logic                  qtr_tick;
  logic                  thr_qtr_tick;

  modport master (
    output run, restart, resync,
    input  baud_cnt, baud_tick, qtr_tick, thr_qtr_tick
  );

  modport slave (
    input  run, restart, resync,
    output baud_cnt, baud_tick, qtr_tick, thr_qtr_tick
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Shared baud counter: counts 0..BAUD_LIMIT and decodes the sample strobes from it.
module uart_baud_counter
  import uart_pkg::*;
#(
    parameter int BAUD_LIMIT   = 10,
    parameter int QTR_BAUD     = 2,
    parameter int THR_QTR_BAUD = 8
) (
    input logic                   clk,
    input logic                   rst,
          uart_parameters_unit_if.slave bus
);

    localparam logic [UART_CNT_W-1:0] LIMIT_V   = UART_CNT_W'(BAUD_LIMIT);
    localparam logic [UART_CNT_W-1:0] QTR_V     = UART_CNT_W'(QTR_BAUD);
    localparam logic [UART_CNT_W-1:0] THR_QTR_V = UART_CNT_W'(THR_QTR_BAUD);

    logic [UART_CNT_W-1:0] cnt;
    baud_strobe_t          strobe;

    // An unknown control falls through to the idle branch, so cnt stays defined.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (bus.resync) begin
            cnt <= '0;
        end else if (bus.restart) begin
            cnt <= UART_CNT_W'(1);
        end else if (bus.run) begin
            cnt <= (cnt == LIMIT_V) ? '0 : cnt + UART_CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    always_comb begin
        strobe         = '0;
        strobe.baud    = (cnt == '0);
        strobe.qtr     = (cnt == QTR_V);
        strobe.thr_qtr = (cnt == THR_QTR_V);
    end

    assign bus.baud_cnt     = cnt;
    assign bus.baud_tick    = strobe.baud;
    assign bus.qtr_tick     = strobe.qtr;
    assign bus.thr_qtr_tick = strobe.thr_qtr;

endmodule

// File: rtl/uart_parameters_unit.sv
// UART configuration constants (referenced hierarchically as params.*) exported on
// cfg_* ports, plus the shared baud-timing counter.
module uart_parameters_unit
  import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = DEF_CLOCK_FREQ,
    parameter int BAUD_RATE  = DEF_BAUD_RATE,
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int STOP_BITS  = DEF_STOP_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
           uart_parameters_unit_if.slave bus,
    output logic [31:0]                  cfg_clock_freq,
    output logic [31:0]                  cfg_baud_rate,
    output logic [7:0]                   cfg_word_size,
    output logic [15:0]                  cfg_baud_limit
);

    localparam int BAUD_LIMIT   = calc_baud_limit(CLOCK_FREQ, BAUD_RATE);
    localparam int QTR_BAUD     = calc_qtr_baud(BAUD_LIMIT);
    localparam int THR_QTR_BAUD = calc_thr_qtr_baud(BAUD_LIMIT);
    localparam int CNT_W        = UART_CNT_W;
    localparam int BIT_CNT_W    = $clog2(WORD_SIZE);

    if (BAUD_RATE <= 0) begin : g_bad_rate
        $fatal(1, "uart_parameters_unit: BAUD_RATE must be positive");
    end
    if (BAUD_LIMIT < 8 || BAUD_LIMIT > 65535) begin : g_bad_limit
        $fatal(1, "uart_parameters_unit: BAUD_LIMIT out of range 8..65535");
    end
    if (WORD_SIZE < 5 || WORD_SIZE > 16) begin : g_bad_word
        $fatal(1, "uart_parameters_unit: WORD_SIZE out of range 5..16");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "uart_parameters_unit: STOP_BITS must be 1 or 2");
    end
    if (QTR_BAUD >= THR_QTR_BAUD) begin : g_bad_points
        $fatal(1, "uart_parameters_unit: quarter point must precede three-quarter point");
    end
    // The receiver's bit index must be able to address every data bit.
    if ((1 << BIT_CNT_W) < WORD_SIZE || CNT_W != 16) begin : g_bad_widths
        $fatal(1, "uart_parameters_unit: counter widths inconsistent");
    end

    assign cfg_clock_freq = 32'(CLOCK_FREQ);
    assign cfg_baud_rate  = 32'(BAUD_RATE);
    assign cfg_word_size  = 8'(WORD_SIZE);
    assign cfg_baud_limit = 16'(BAUD_LIMIT);

    uart_baud_counter #(
        .BAUD_LIMIT  (BAUD_LIMIT),
        .QTR_BAUD    (QTR_BAUD),
        .THR_QTR_BAUD(THR_QTR_BAUD)
    ) u_baud_counter (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

endmodule

// File: tb/tb_uart_parameters_unit.sv
// Bench for uart_parameters_unit at CLOCK_FREQ=1000, BAUD_RATE=100 (11 clocks per bit).
module tb_uart_parameters_unit;

    localparam int CF      = 1000;
    localparam int BR      = 100;
    localparam int LIMIT   = CF / BR;
    localparam int PERIOD  = LIMIT + 1;
    localparam int QTR     = LIMIT / 4;
    localparam int THR_QTR = (LIMIT * 4) / 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_clock_freq;
    logic [31:0] cfg_baud_rate;
    logic [7:0]  cfg_word_size;
    logic [15:0] cfg_baud_limit;

    int n_tests = 0;
    int n_fail  = 0;
    int phase   = 0;

    uart_parameters_unit_if bif ();

    uart_parameters_unit #(
        .CLOCK_FREQ(CF),
        .BAUD_RATE (BR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bif),
        .cfg_clock_freq(cfg_clock_freq),
        .cfg_baud_rate (cfg_baud_rate),
        .cfg_word_size (cfg_word_size),
        .cfg_baud_limit(cfg_baud_limit)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] expect_vec(input int ph);
        return {16'(ph), ph == 0, ph == QTR, ph == THR_QTR};
    endfunction

    function automatic logic [18:0] observed_vec();
        return {bif.baud_cnt, bif.baud_tick, bif.qtr_tick, bif.thr_qtr_tick};
    endfunction

    // One clock edge; the model follows the position-within-bit rules, then outputs settle.
    task automatic step();
        @(posedge clk);
        if (rst || bif.resync) phase = 0;
        else if (bif.restart)  phase = 1;
        else if (bif.run)      phase = (phase + 1) % PERIOD;
        else                   phase = 0;
        #1;
    endtask

    task automatic drive(input logic r, input logic rs, input logic rt, input logic rn);
        rst = r; bif.resync = rs; bif.restart = rt; bif.run = rn;
    endtask

    task automatic run_to(input int target);
        int budget = 2 * PERIOD;
        drive(0, 0, 0, 1);
        while (phase != target && budget > 0) begin
            step();
            budget--;
        end
        n_tests++;
        if (phase != target) begin
            n_fail++;
            $display("FAIL run_to: model phase %0d, wanted %0d", phase, target);
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0);
        step();
        step();
        n_tests++;
        if (observed_vec() !== expect_vec(0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", observed_vec(), expect_vec(0));
        end
        n_tests++;
        if (cfg_baud_limit !== 16'd10) begin
            n_fail++;
            $display("FAIL cfg_baud_limit: got %0d want 10", cfg_baud_limit);
        end
        n_tests++;
        if (cfg_word_size !== 8'd8) begin
            n_fail++;
            $display("FAIL cfg_word_size: got %0d want 8", cfg_word_size);
        end
        n_tests++;
        if (cfg_clock_freq !== 32'd1000 || cfg_baud_rate !== 32'd100) begin
            n_fail++;
            $display("FAIL cfg_freq_rate: got %0d/%0d want 1000/100", cfg_clock_freq, cfg_baud_rate);
        end
    endtask

    task automatic test_run_sequence();
        int nb = 0, nq = 0, nt = 0;
        drive(0, 0, 0, 1);
        for (int i = 1; i <= 22; i++) begin
            step();
            n_tests++;
            if (observed_vec() !== expect_vec(i % PERIOD)) begin
                n_fail++;
                $display("FAIL run_seq[%0d]: got %h want %h", i, observed_vec(), expect_vec(i % PERIOD));
            end
            nb += int'(bif.baud_tick);
            nq += int'(bif.qtr_tick);
            nt += int'(bif.thr_qtr_tick);
        end
        n_tests++;
        if (nb != 2 || nq != 2 || nt != 2) begin
            n_fail++;
            $display("FAIL tick_counts: got %0d/%0d/%0d want 2/2/2", nb, nq, nt);
        end
    endtask

    task automatic test_run_drop();
        run_to(5);
        n_tests++;
        if (bif.baud_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL drop_pre: got %0d want 5", bif.baud_cnt);
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (observed_vec() !== expect_vec(0)) begin
                n_fail++;
                $display("FAIL drop_hold[%0d]: got %h want %h", i, observed_vec(), expect_vec(0));
            end
        end
    endtask

    task automatic test_restart_resync();
        run_to(7);
        drive(0, 0, 1, 1);
        step();
        n_tests++;
        if (bif.baud_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL restart_at_7: got %0d want 1", bif.baud_cnt);
        end
        run_to(3);
        drive(0, 1, 1, 1);
        step();
        n_tests++;
        if (bif.baud_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL resync_wins: got %0d want 0", bif.baud_cnt);
        end
        run_to(4);
        drive(0, 0, 1, 0);
        step();
        n_tests++;
        if (bif.baud_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL restart_idle: got %0d want 1", bif.baud_cnt);
        end
        drive(0, 1, 0, 1);
        step();
        n_tests++;
        if (bif.baud_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL resync_run: got %0d want 0", bif.baud_cnt);
        end
    endtask

    task automatic test_reset_midcount();
        run_to(6);
        drive(1, 0, 1, 1);
        step();
        n_tests++;
        if (observed_vec() !== expect_vec(0)) begin
            n_fail++;
            $display("FAIL rst_mid: got %h want %h", observed_vec(), expect_vec(0));
        end
        drive(0, 0, 0, 1);
        step();
        n_tests++;
        if (bif.baud_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_resume: got %0d want 1", bif.baud_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 14) == 0, $urandom_range(0, 9) != 0);
            step();
            n_tests++;
            if (observed_vec() !== expect_vec(phase)) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, observed_vec(), expect_vec(phase));
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 0);
        test_reset();
        test_run_sequence();
        test_run_drop();
        test_restart_resync();
        test_reset_midcount();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
